// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32
// load/store funct3 codes, byte-lane strobe and alignment functions.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_byte(input logic [2:0] func3);
        return (func3 == F3_B) || (func3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] func3);
        return (func3 == F3_H) || (func3 == F3_HU);
    endfunction

    // Unused encodings (011, 110, 111) fall through to word width.
    function automatic logic [3:0] wstrb_of(input logic [2:0] func3, input logic [1:0] off);
        if (is_byte(func3))
            return 4'b0001 << off;
        else if (is_half(func3))
            return 4'b0011 << off;
        else
            return 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] off);
        if (is_byte(func3))
            return 1'b0;
        else if (is_half(func3))
            return off[0];
        else
            return off != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the byte/half lane from the bus word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mem_rdata[{off, 3'b000} +: 8];
        lane_h = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        result = mem_rdata;
        case (func3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'b0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'b0, lane_h};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the execute stage to a request/grant/response
// data bus: one transaction per instruction, stalls the pipe until done.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            misalign_err,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state_q, state_d;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            misalign_q;
    logic            bus_err_q;
    logic [31:0]     cnt_q;

    logic            accept;
    logic            mis_now;
    logic            timeout_hit;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] load_ext;

    assign accept      = req_valid & (mem_read | mem_write);
    assign mis_now     = misaligned(func3, addr[1:0]);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

    always_comb begin
        wdata_rep = wdata;
        if (is_byte(func3))
            wdata_rep = {4{wdata[7:0]}};
        else if (is_half(func3))
            wdata_rep = {2{wdata[15:0]}};
    end

    lsu_load_align u_align (
        .mem_rdata (mem_rdata),
        .func3     (f3_q),
        .off       (off_q),
        .result    (load_ext)
    );

    // The awaited bus event is tested before the timeout so it wins a tie.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = mis_now ? DONE : REQ;
            REQ: begin
                if (mem_gnt)          state_d = we_q ? DONE : RESP;
                else if (timeout_hit) state_d = DONE;
            end
            RESP: begin
                if (mem_rvalid)       state_d = DONE;
                else if (timeout_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            f3_q       <= '0;
            off_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        f3_q       <= func3;
                        off_q      <= addr[1:0];
                        we_q       <= mem_write;
                        addr_q     <= {addr[XLEN-1:2], 2'b00};
                        wdata_q    <= wdata_rep;
                        rdata_q    <= '0;
                        misalign_q <= mis_now;
                        bus_err_q  <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                REQ: begin
                    if (mem_gnt)          cnt_q     <= '0;
                    else if (timeout_hit) bus_err_q <= 1'b1;
                    else                  cnt_q     <= cnt_q + 32'd1;
                end
                RESP: begin
                    if (mem_rvalid)       rdata_q   <= load_ext;
                    else if (timeout_hit) bus_err_q <= 1'b1;
                    else                  cnt_q     <= cnt_q + 32'd1;
                end
                DONE: begin
                    misalign_q <= 1'b0;
                    bus_err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign done         = (state_q == DONE);
    assign stall        = accept & ~done;
    assign rdata        = done ? rdata_q : '0;
    assign misalign_err = done & misalign_q;
    assign bus_err      = done & bus_err_q;

    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wstrb = (mem_req && we_q) ? wstrb_of(f3_q, off_q) : 4'b0000;
    assign mem_wdata = (mem_req && we_q) ? wdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with hand-computed expectations; the DUT
// runs with TIMEOUT=4 so bus timeouts are reachable in a few cycles.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign_err, bus_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(.TIMEOUT(4), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .func3        (func3),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .rdata        (rdata),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven there
    // and outputs sampled after a further settling delay.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic present(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        mem_read  = ~wr;
        mem_write = wr;
        func3     = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_req"},   {31'b0, mem_req}, 32'd0);
        check({tag, ".mem_we"},    {31'b0, mem_we}, 32'd0);
        check({tag, ".mem_addr"},  mem_addr, 32'd0);
        check({tag, ".mem_wstrb"}, {28'b0, mem_wstrb}, 32'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        check({tag, ".done"},      {31'b0, done}, 32'd0);
        check({tag, ".rdata"},     rdata, 32'd0);
        check({tag, ".misalign"},  {31'b0, misalign_err}, 32'd0);
        check({tag, ".bus_err"},   {31'b0, bus_err}, 32'd0);
        check({tag, ".stall"},     {31'b0, stall}, 32'd0);
    endtask

    // Store: request in cycle 0, mem_req from cycle 1, grant after gnt_wait
    // extra cycles, done the cycle after the grant.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int gnt_wait,
                            input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        tick();
        present(1'b1, f3, a, wd);
        settle();
        check({tag, ".c0.stall"},   {31'b0, stall}, 32'd1);
        check({tag, ".c0.mem_req"}, {31'b0, mem_req}, 32'd0);
        for (int c = 0; c <= gnt_wait; c++) begin
            tick();
            mem_gnt = (c == gnt_wait);
            settle();
            check({tag, ".mem_req"},   {31'b0, mem_req}, 32'd1);
            check({tag, ".mem_we"},    {31'b0, mem_we}, 32'd1);
            check({tag, ".mem_addr"},  mem_addr, exp_addr);
            check({tag, ".mem_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_strb});
            check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
            check({tag, ".stall"},     {31'b0, stall}, 32'd1);
            check({tag, ".done"},      {31'b0, done}, 32'd0);
        end
        tick();
        mem_gnt = 1'b0;
        settle();
        check({tag, ".done"},     {31'b0, done}, 32'd1);
        check({tag, ".stall"},    {31'b0, stall}, 32'd0);
        check({tag, ".mem_req"},  {31'b0, mem_req}, 32'd0);
        check({tag, ".misalign"}, {31'b0, misalign_err}, 32'd0);
        check({tag, ".bus_err"},  {31'b0, bus_err}, 32'd0);
        tick();
        idle_inputs();
        settle();
        check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    // Load: grant in cycle 1, rvalid in cycle 3, done in cycle 4.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp_addr,
                           input logic [31:0] exp_rdata);
        tick();
        present(1'b0, f3, a, 32'h0);
        settle();
        check({tag, ".c0.stall"}, {31'b0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b1;
        settle();
        check({tag, ".c1.mem_req"},   {31'b0, mem_req}, 32'd1);
        check({tag, ".c1.mem_we"},    {31'b0, mem_we}, 32'd0);
        check({tag, ".c1.mem_addr"},  mem_addr, exp_addr);
        check({tag, ".c1.mem_wstrb"}, {28'b0, mem_wstrb}, 32'd0);
        tick();
        mem_gnt = 1'b0;
        settle();
        check({tag, ".c2.mem_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, ".c2.stall"},   {31'b0, stall}, 32'd1);
        check({tag, ".c2.wstrb"},   {28'b0, mem_wstrb}, 32'd0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        settle();
        check({tag, ".c3.done"}, {31'b0, done}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_0000;
        settle();
        check({tag, ".c4.done"},  {31'b0, done}, 32'd1);
        check({tag, ".c4.rdata"}, rdata, exp_rdata);
        check({tag, ".c4.stall"}, {31'b0, stall}, 32'd0);
        check({tag, ".c4.err"},   {30'b0, misalign_err, bus_err}, 32'd0);
        tick();
        idle_inputs();
        settle();
        check({tag, ".c5.done"}, {31'b0, done}, 32'd0);
    endtask

    task automatic do_misaligned(input string tag, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a);
        tick();
        present(wr, f3, a, 32'hFFFF_FFFF);
        settle();
        check({tag, ".c0.mem_req"}, {31'b0, mem_req}, 32'd0);
        tick();
        settle();
        check({tag, ".c1.done"},     {31'b0, done}, 32'd1);
        check({tag, ".c1.misalign"}, {31'b0, misalign_err}, 32'd1);
        check({tag, ".c1.bus_err"},  {31'b0, bus_err}, 32'd0);
        check({tag, ".c1.rdata"},    rdata, 32'd0);
        check({tag, ".c1.mem_req"},  {31'b0, mem_req}, 32'd0);
        tick();
        idle_inputs();
        settle();
        check({tag, ".c2.done"},     {31'b0, done}, 32'd0);
        check({tag, ".c2.misalign"}, {31'b0, misalign_err}, 32'd0);
        check({tag, ".c2.mem_req"},  {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        idle_inputs();
        func3     = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        repeat (3) tick();
        settle();
        check_all_zero("reset");
        rst = 1'b0;

        // Stores
        do_store("sb_1003", 3'b000, 32'h0000_1003, 32'h0000_00A5, 0,
                 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
        do_store("sh_1002", 3'b001, 32'h0000_1002, 32'h1234_BEEF, 0,
                 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF);
        do_store("sw_gnt2", 3'b010, 32'h0000_7004, 32'h1122_3344, 2,
                 32'h0000_7004, 4'b1111, 32'h1122_3344);
        do_store("sb_lane1", 3'b000, 32'h0000_0101, 32'hFFFF_FF3C, 1,
                 32'h0000_0100, 4'b0010, 32'h3C3C_3C3C);

        // Loads
        do_load("lb_2001",  3'b000, 32'h0000_2001, 32'h1234_8056, 32'h0000_2000, 32'hFFFF_FF80);
        do_load("lbu_2001", 3'b100, 32'h0000_2001, 32'h1234_8056, 32'h0000_2000, 32'h0000_0080);
        do_load("lb_2003",  3'b000, 32'h0000_2003, 32'h7F00_00FF, 32'h0000_2000, 32'h0000_007F);
        do_load("lhu_3002", 3'b101, 32'h0000_3002, 32'hBEEF_1234, 32'h0000_3000, 32'h0000_BEEF);
        do_load("lh_3002",  3'b001, 32'h0000_3002, 32'hBEEF_1234, 32'h0000_3000, 32'hFFFF_BEEF);
        do_load("lh_3000",  3'b001, 32'h0000_3000, 32'hBEEF_1234, 32'h0000_3000, 32'h0000_1234);
        do_load("lw_4000",  3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0000_4000, 32'hDEAD_BEEF);
        do_load("l011_w",   3'b011, 32'h0000_4008, 32'h8000_0001, 32'h0000_4008, 32'h8000_0001);

        // Misaligned accesses never reach the bus
        do_misaligned("lw_4002", 1'b0, 3'b010, 32'h0000_4002);
        do_misaligned("sh_5001", 1'b1, 3'b001, 32'h0000_5001);
        do_misaligned("lhu_5003", 1'b0, 3'b101, 32'h0000_5003);

        // Load timeout in RESP: RESP entered in cycle 2, bus_err in cycle 6
        tick();
        present(1'b0, 3'b010, 32'h0000_6000, 32'h0);
        tick();
        mem_gnt = 1'b1;
        settle();
        check("to_load.c1.mem_req", {31'b0, mem_req}, 32'd1);
        tick();
        mem_gnt = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            settle();
            check("to_load.wait.done", {31'b0, done}, 32'd0);
            check("to_load.wait.stall", {31'b0, stall}, 32'd1);
            tick();
        end
        settle();
        check("to_load.c6.done",    {31'b0, done}, 32'd1);
        check("to_load.c6.bus_err", {31'b0, bus_err}, 32'd1);
        check("to_load.c6.misal",   {31'b0, misalign_err}, 32'd0);
        check("to_load.c6.rdata",   rdata, 32'd0);
        tick();
        idle_inputs();
        settle();
        check("to_load.c7.bus_err", {31'b0, bus_err}, 32'd0);
        do_store("after_to", 3'b010, 32'h0000_7000, 32'h1122_3344, 0,
                 32'h0000_7000, 4'b1111, 32'h1122_3344);

        // Store timeout in REQ: REQ cycles 1..4, bus_err in cycle 5
        tick();
        present(1'b1, 3'b010, 32'h0000_7100, 32'hCAFE_F00D);
        tick();
        for (int c = 1; c <= 4; c++) begin
            settle();
            check("to_store.mem_req", {31'b0, mem_req}, 32'd1);
            check("to_store.done",    {31'b0, done}, 32'd0);
            tick();
        end
        settle();
        check("to_store.c5.done",    {31'b0, done}, 32'd1);
        check("to_store.c5.bus_err", {31'b0, bus_err}, 32'd1);
        check("to_store.c5.mem_req", {31'b0, mem_req}, 32'd0);
        tick();
        idle_inputs();

        // Reset while in RESP; a late rvalid afterwards must be ignored
        tick();
        present(1'b0, 3'b010, 32'h0000_8000, 32'h0);
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        settle();
        check("rst_resp.c2.stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        settle();
        check_all_zero("rst_resp.c3");
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        settle();
        check_all_zero("rst_resp.c4");
        tick();
        mem_rvalid = 1'b0;
        settle();
        check_all_zero("rst_resp.c5");

        do_load("after_rst", 3'b100, 32'h0000_9002, 32'h00C3_0000, 32'h0000_9000, 32'h0000_00C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit that sits between the execute stage and the data-memory bus.
- Takes the decoded memory controls (mem_read, mem_write and the load/store func3) plus the ALU address and store data.
- Issues one request/grant/response transaction per instruction, with byte-lane strobes and alignment.
- Returns sign- or zero-extended load data, holding the pipeline stalled until the access completes, times out or is rejected.

Parameters:
- TIMEOUT, 16, cycles allowed in REQ or RESP before bus_err; 0 disables the timeout.
- XLEN, 32, data and address width (fixed at 32 for RV32).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents a memory instruction
- mem_read  in  1  load
- mem_write  in  1  store (mem_read and mem_write are never both 1)
- func3  in  3  RV32 load/store funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective byte address
- wdata  in  32  store source register
- stall  out  1  hold the pipeline
- done  out  1  one-cycle pulse: access finished
- rdata  out  32  extended load result, valid while done=1
- misalign_err  out  1  one-cycle pulse with done: misaligned access
- bus_err  out  1  one-cycle pulse with done: timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address (addr with bits [1:0] cleared)
- mem_wstrb  out  4  byte-lane strobes
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  bus accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset: state IDLE, timeout counter 0, and every output 0 (mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, done, rdata, misalign_err, bus_err, stall).
- Reset mid-operation: mem_req is 0 on the cycle after rst. A late mem_gnt or mem_rvalid arriving in IDLE is ignored.
- stall = req_valid & (mem_read|mem_write) & ~done. It is combinational. The pipeline holds req_valid, addr, func3 and wdata stable while stall=1.
- States: IDLE, REQ, RESP, DONE.
- IDLE, on req_valid & (mem_read|mem_write):
  - Latch func3, addr[1:0] and op.
  - Misaligned (H/HU with addr[0]=1, or W with addr[1:0]≠0): go to DONE with misalign_err=1 and rdata=0. No bus activity.
  - Otherwise go to REQ, driving mem_req=1, mem_we=mem_write and mem_addr={addr[31:2],2'b00} from the next cycle.
- REQ: mem_req and its payload are held until mem_gnt.
  - Store with mem_gnt: go to DONE.
  - Load with mem_gnt: go to RESP, and mem_req=0 from the next cycle.
  - A load with mem_gnt and mem_rvalid in the same cycle is not legal on this bus; the bench never drives it.
- RESP: on mem_rvalid, register rdata from mem_rdata and go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. A new request is not accepted in this cycle (stall=0, so the pipeline advances). Earliest next acceptance is the following cycle.
- Latency:
  - Store with immediate grant: request in cycle 0 (IDLE), mem_req in cycle 1, done in cycle 2.
  - Load with grant in cycle 1 and rvalid in cycle 2: done in cycle 3.
- Strobes (store only; mem_wstrb=0 for loads):
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<addr[1:0].
  - W: 4'b1111.
- Store data: byte replicated ×4, half replicated ×2, word as is.
- Load extraction (on latched addr[1:0]):
  - B: sign-extend byte lane addr[1:0].
  - BU: zero-extend byte lane addr[1:0].
  - H: sign-extend half lane addr[1].
  - HU: zero-extend half lane addr[1].
  - W: full word.
- func3 011, 110 or 111: treated as W.
- Timeout:
  - Counter clears on entry to REQ and again on the REQ→RESP transition, and increments each cycle spent in REQ or RESP.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without the awaited event: go to DONE with bus_err=1 and rdata=0, and mem_req drops the next cycle.
  - If the awaited event occurs on the same cycle the counter reaches TIMEOUT-1, the event wins.

Decomposition:
- Package lsu_pkg holds:
  - the state enum;
  - func3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - a wstrb_of(func3, off) function;
  - a misaligned(func3, off) function.
- Sub-module lsu_load_align is combinational: (mem_rdata, func3, off) → 32-bit extended result. It is reused by the future cache path.

Test Plan:
- SB to 0x1003 with wdata 0x000000A5 and immediate gnt → mem_addr 0x1000, mem_wstrb 1000, mem_wdata 0xA5A5A5A5, done in cycle 2, stall high for cycles 0-1.
- LB from 0x2001, gnt in cycle 1, rvalid in cycle 3 with rdata 0x12348056 → rdata 0x00000080 is wrong; required rdata=0xFFFFFF80. Repeat as LBU → 0x00000080.
- LHU from 0x3002 with rdata 0xBEEF1234 → 0x0000BEEF; LH → 0xFFFFBEEF; mem_wstrb=0 throughout.
- LW from 0x4002 → misalign_err and done in cycle 1, mem_req never asserted, rdata 0.
- LW with TIMEOUT=4 and rvalid never asserted → bus_err+done exactly 4 cycles after RESP entry, rdata 0, then next request accepted normally.
- rst asserted while in RESP, rvalid arrives 2 cycles later → all outputs 0, state IDLE, no done pulse.
